cmp_seq_arb: RTL and testbench
==============================

Name: cmp_seq_arb

Overview:
- Shared magnitude-compare engine for the 16-bit CPU. Arbitrates up to NREQ requesters round-robin onto a single SLICE-bit comparator slice.
- Compares WIDTH-bit operands one slice per cycle, MSB slice first, and exits early on the first unequal slice.
- Returns one-hot eq/gt/lt flags, tagged with the requester id, over a valid/ready response channel.
- Replaces per-unit wide comparators (branch unit, ALU flags, address checks) with one time-shared engine.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width; must be an integer multiple of SLICE.
- SLICE, 4, bits compared per cycle; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  grant/accept strobe, at most one bit high, combinational from state and req_valid.
- req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing.
- rsp_valid  output  1  result valid, registered.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
- rsp_eq  output  1  A == B.
- rsp_gt  output  1  A > B.
- rsp_lt  output  1  A < B.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rr_ptr=0, slice index=0, captured operands=0. All outputs are 0: rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt, busy, req_ready.
- Reset mid-operation: the in-flight compare and any pending result are dropped. No response is ever emitted for them.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - If any req_valid is high, grant the first valid index at or above rr_ptr, wrapping modulo NREQ.
  - req_ready[grant]=1 in that cycle; the handshake completes in that cycle.
  - Latch a_q/b_q and id_q from the granted requester, set idx=NSLICE-1, go to CMP.
  - With no req_valid, stay in IDLE; req_ready=0.
- CMP: each cycle compare slice idx of a_q/b_q (unsigned).
  - Slice greater: set gt=1, go to DONE.
  - Slice less: set lt=1, go to DONE.
  - Slice equal and idx==0: set eq=1, go to DONE.
  - Slice equal and idx>0: decrement idx, stay in CMP.
  - req_ready=0 for all requesters throughout CMP.
- DONE:
  - rsp_valid=1; rsp_id/eq/gt/lt are stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid && rsp_ready: rsp_valid drops next cycle, rr_ptr = (id_q+1) mod NREQ, go to IDLE.
  - No new grant is issued in the handshake cycle; the earliest new req_ready is the following cycle.
- Flag invariant: exactly one of rsp_eq/gt/lt is high whenever rsp_valid=1. Flags keep their last values after the handshake until the next result is written.
- Latency from accept (cycle 0) to first rsp_valid:
  - Differ in the MSB slice: rsp_valid at cycle 2.
  - First difference in slice k: rsp_valid at cycle NSLICE-k+1.
  - Equal operands: rsp_valid at cycle NSLICE+1 (5 at defaults).
- Throughput: at best one compare every (latency+1) cycles.
- Operands are sampled only on the accept cycle. Changes on req_a/req_b afterwards have no effect.
- Requesters must hold req_valid and operands until req_ready. A requester deasserting before grant is legal and is simply skipped.
- Starvation: round-robin guarantees service within NREQ grants for any continuously asserted request.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined:
  - Adds input req_signed, NREQ wide, latched with the operands on accept.
  - For a signed request, the MSB slice is compared with both operand MSBs inverted (two's-complement order). Lower slices remain unsigned.
  - Early exit and latency are unchanged.
- Undefined: port absent; all compares are unsigned.

Test Plan:
- rst=1 mid-CMP (A=0x1234, B=0x1235, req0) -> next cycle all outputs 0, state IDLE. No response after release, even with rsp_ready=1.
- req0 alone, A=0x8000, B=0x7FFF -> accept cycle 0, rsp_valid at cycle 2: gt=1, eq=lt=0, rsp_id=0.
- req1 alone, A=B=0xBEEF -> rsp_valid at cycle 5: eq=1, rsp_id=1. Hold rsp_ready=0 for 3 cycles -> flags and id stable, then one handshake and rsp_valid=0.
- req2 alone, A=0x00A3, B=0x00A7 -> rsp_valid at cycle 5 (first difference in slice 0): lt=1, rsp_id=2.
- All four requesters valid continuously from reset, distinct operands -> grant order 0,1,2,3,0; never more than one req_ready bit high; no grant in any rsp handshake cycle.
- With CMP_SIGNED_EN: A=0xFFFF, B=0x0001, req_signed=1 -> lt=1. Same operands with req_signed=0 -> gt=1.

Source files
------------

// File: rtl/cmp_seq_arb_if.sv
// rtl/cmp_seq_arb_if.sv - request/response bundle for the shared compare engine (req_signed present under CMP_SIGNED_EN)
interface cmp_seq_arb_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
`ifdef CMP_SIGNED_EN
  logic [NREQ-1:0]       req_signed;
`endif
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_eq;
  logic                  rsp_gt;
  logic                  rsp_lt;
  logic                  busy;

  // Requester/consumer side
  modport master (
`ifdef CMP_SIGNED_EN
    output req_signed,
`endif
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt, busy
  );

  // Compare engine side
  modport slave (
`ifdef CMP_SIGNED_EN
    input  req_signed,
`endif
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt, busy
  );
endinterface

// File: rtl/cmp_seq_arb.sv
// rtl/cmp_seq_arb.sv - round-robin shared slice-serial magnitude comparator (optional signed mode: CMP_SIGNED_EN)
module cmp_seq_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic          clk,
  input  logic          rst,
  cmp_seq_arb_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;
`ifdef CMP_SIGNED_EN
  logic             r_signed;
`endif

  logic             w_gnt_found;
  logic [IDW-1:0]   w_gnt_id;
  logic [NREQ-1:0]  w_gnt_oh;
  logic             w_accept;
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic             w_sgt;
  logic             w_slt;
  logic             w_rsp_fire;

  // Index of the requester 'offs' positions after 'base', wrapping at NREQ
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Round-robin search: scanning from the far end down makes the nearest valid requester win
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_index(r_rr_ptr, k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = rr_index(r_rr_ptr, k);
      end
    end
  end

  // Grant strobe only while idle; held low during reset so no handshake can complete then
  always_comb begin
    w_gnt_oh = '0;
    if (r_state == IDLE && w_gnt_found && !rst) w_gnt_oh[w_gnt_id] = 1'b1;
  end

  assign w_accept   = |w_gnt_oh;
  assign w_rsp_fire = (r_state == DONE) && bus.rsp_ready;

  // Current slice of the captured operands; signed mode flips the sign bits of the top slice
  always_comb begin
    w_sa = r_a[r_idx*SLICE +: SLICE];
    w_sb = r_b[r_idx*SLICE +: SLICE];
`ifdef CMP_SIGNED_EN
    if (r_signed && r_idx == LAST_IDX) begin
      w_sa[SLICE-1] = ~w_sa[SLICE-1];
      w_sb[SLICE-1] = ~w_sb[SLICE-1];
    end
`endif
    w_sgt = (w_sa > w_sb);
    w_slt = (w_sa < w_sb);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: exit CMP on first unequal slice or after the last slice
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = CMP;
      CMP:  if (w_sgt || w_slt || r_idx == '0) w_next = DONE;
      DONE: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, slice walk, result flags and round-robin pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
`ifdef CMP_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_a   <= bus.req_a[w_gnt_id*WIDTH +: WIDTH];
        r_b   <= bus.req_b[w_gnt_id*WIDTH +: WIDTH];
        r_id  <= w_gnt_id;
        r_idx <= LAST_IDX;
`ifdef CMP_SIGNED_EN
        r_signed <= bus.req_signed[w_gnt_id];
`endif
      end
      if (r_state == CMP) begin
        if (w_sgt) begin
          r_gt <= 1'b1;
          r_lt <= 1'b0;
          r_eq <= 1'b0;
        end else if (w_slt) begin
          r_gt <= 1'b0;
          r_lt <= 1'b1;
          r_eq <= 1'b0;
        end else if (r_idx == '0) begin
          r_gt <= 1'b0;
          r_lt <= 1'b0;
          r_eq <= 1'b1;
        end else begin
          r_idx <= r_idx - IDXW'(1);
        end
      end
      if (w_rsp_fire) r_rr_ptr <= (r_id == LAST_ID) ? '0 : r_id + IDW'(1);
    end
  end

  assign bus.req_ready = w_gnt_oh;
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_eq    = r_eq;
  assign bus.rsp_gt    = r_gt;
  assign bus.rsp_lt    = r_lt;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_cmp_seq_arb.sv
// tb/tb_cmp_seq_arb.sv - scoreboard bench for cmp_seq_arb with a behavioural arbitration/compare model
module tb_cmp_seq_arb;
  localparam int NREQ   = 4;
  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_seq_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  cmp_seq_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int   id;
    logic eq;
    logic gt;
    logic lt;
    int   due;
  } exp_t;

  int              n_pass = 0;
  int              n_total = 0;
  int              cyc = 0;
  exp_t            sbq[$];
  int              grant_log[$];
  logic [NREQ-1:0] acc_mask = '0;
  logic            outst = 1'b0;
  int              m_ptr = 0;
  logic            in_rsp = 1'b0;

  int               m_gid;
  int               m_msb;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic [WIDTH-1:0] m_x;
  logic [NREQ-1:0]  m_exp_ready;
  logic             m_sg;
  exp_t             m_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor and reference model: mid-cycle sampling of grants and responses
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id,
                            bus.rsp_eq, bus.rsp_gt, bus.rsp_lt}, '0);
      sbq.delete();
      outst    = 1'b0;
      m_ptr    = 0;
      in_rsp   = 1'b0;
      acc_mask = '0;
    end else begin
      m_exp_ready = '0;
      m_gid = -1;
      if (!outst) begin
        for (int k = 0; k < NREQ; k++)
          if (m_gid < 0 && bus.req_valid[(m_ptr + k) % NREQ]) m_gid = (m_ptr + k) % NREQ;
      end
      if (m_gid >= 0) m_exp_ready[m_gid] = 1'b1;
      chk("req_ready", bus.req_ready, m_exp_ready);
      chk("busy", bus.busy, outst);
      acc_mask = m_exp_ready;
      if (m_gid >= 0) begin
        m_a  = bus.req_a[m_gid*WIDTH +: WIDTH];
        m_b  = bus.req_b[m_gid*WIDTH +: WIDTH];
        m_sg = 1'b0;
`ifdef CMP_SIGNED_EN
        m_sg = bus.req_signed[m_gid];
`endif
        m_e.id = m_gid;
        m_e.eq = (m_a == m_b);
        m_e.gt = m_sg ? ($signed(m_a) > $signed(m_b)) : (m_a > m_b);
        m_e.lt = m_sg ? ($signed(m_a) < $signed(m_b)) : (m_a < m_b);
        if (m_a == m_b) m_e.due = cyc + NSLICE + 1;
        else begin
          m_x = m_a ^ m_b;
          m_msb = 0;
          for (int i = 0; i < WIDTH; i++) if (m_x[i]) m_msb = i;
          m_e.due = cyc + NSLICE - (m_msb / SLICE) + 1;
        end
        sbq.push_back(m_e);
        grant_log.push_back(m_gid);
        outst = 1'b1;
      end
      if (sbq.size() > 0 && !in_rsp && cyc == sbq[0].due)
        chk("rsp_valid_at_due", bus.rsp_valid, 1'b1);
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected no response (cycle %0d)",
                   bus.rsp_id, cyc);
        end else begin
          m_e = sbq[0];
          if (!in_rsp) chk("rsp_latency", cyc, m_e.due);
          chk("rsp_id", bus.rsp_id, m_e.id);
          chk("rsp_flags", {bus.rsp_eq, bus.rsp_gt, bus.rsp_lt}, {m_e.eq, m_e.gt, m_e.lt});
          in_rsp = 1'b1;
          if (bus.rsp_ready) begin
            void'(sbq.pop_front());
            in_rsp = 1'b0;
            outst  = 1'b0;
            m_ptr  = (m_e.id + 1) % NREQ;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_a[id*WIDTH +: WIDTH] = a;
    bus.req_b[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic rand_ops(input int id);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = WIDTH'($urandom);
    case ($urandom_range(0, 3))
      0: b = a;
      1: b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      2: b = WIDTH'($urandom);
      default: begin a = WIDTH'($urandom_range(0, 31)); b = WIDTH'($urandom_range(0, 31)); end
    endcase
    set_ops(id, a, b);
`ifdef CMP_SIGNED_EN
    bus.req_signed[id] = 1'($urandom);
`endif
  endtask

  task automatic wait_acc(input int id);
    logic got;
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      tick();
      if (acc_mask[id]) got = 1'b1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL accept_timeout: got no grant for req%0d expected grant within 30 cycles", id);
    end
  endtask

  task automatic drain(input int limit);
    for (int t = 0; t < limit && sbq.size() != 0; t++) tick();
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
    end
  endtask

  task automatic one_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sg, input int hold);
    int held;
    held = 0;
    bus.rsp_ready = (hold == 0);
    set_ops(id, a, b);
`ifdef CMP_SIGNED_EN
    bus.req_signed[id] = sg;
`else
    if (sg) $display("note: signed request issued on an unsigned build");
`endif
    bus.req_valid[id] = 1'b1;
    wait_acc(id);
    bus.req_valid[id] = 1'b0;
    set_ops(id, ~a, b ^ 16'h5A5A);
    for (int t = 0; t < 40 && sbq.size() != 0; t++) begin
      if (bus.rsp_valid && held < hold) begin
        bus.rsp_ready = 1'b0;
        held++;
      end else begin
        bus.rsp_ready = (held >= hold);
      end
      tick();
    end
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL rsp_timeout: got no response for req%0d expected one", id);
    end
    chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b0;
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
`ifdef CMP_SIGNED_EN
    bus.req_signed = '0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of a compare drops it
    bus.rsp_ready = 1'b1;
    set_ops(0, 16'h1234, 16'h1235);
    bus.req_valid[0] = 1'b1;
    wait_acc(0);
    bus.req_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    bus.rsp_ready = 1'b0;

    one_req(0, 16'h8000, 16'h7FFF, 1'b0, 0);
    one_req(1, 16'hBEEF, 16'hBEEF, 1'b0, 3);
    one_req(2, 16'h00A3, 16'h00A7, 1'b0, 0);
`ifdef CMP_SIGNED_EN
    one_req(3, 16'hFFFF, 16'h0001, 1'b1, 0);
    one_req(3, 16'hFFFF, 16'h0001, 1'b0, 0);
`endif

    // All requesters valid from reset: round-robin order
    rst = 1'b1;
    tick();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      set_ops(i, WIDTH'(16'h1000 * (i + 1)), WIDTH'(16'h0F00 * (i + 2)));
      bus.req_valid[i] = 1'b1;
    end
    repeat (2) tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 200 && grant_log.size() < 5; t++) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (acc_mask[i]) rand_ops(i);
    end
    for (int g = 0; g < 5; g++) begin
      if (g < grant_log.size()) chk($sformatf("rr_order_%0d", g), grant_log[g], rr_exp[g]);
      else begin
        n_total++;
        $display("FAIL rr_order_%0d: got no grant expected req%0d", g, rr_exp[g]);
      end
    end
    bus.req_valid = '0;
    drain(40);

    // Randomised traffic with back-pressure and early withdrawals
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          bus.req_valid[i] = 1'b0;
          rand_ops(i);
        end
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          rand_ops(i);
          bus.req_valid[i] = 1'b1;
        end else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    drain(40);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
